// File: rtl/fir_mac_sequencer_if.sv
// Sample/coefficient/result bundle between a host and the sequential FIR MAC.
// Control and sample inputs flow master->slave; result and status flags flow back.
`timescale 1ns/1ps
interface fir_mac_sequencer_if #(
  parameter int TAPS = 4
);
  localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;

  logic                 ena;
  logic                 sample_valid;
  logic signed [7:0]    sample_in;
  logic                 coef_we;
  logic [IW-1:0]        coef_idx;
  logic signed [7:0]    coef_data;
  logic signed [7:0]    y_out;
  logic                 y_valid;
  logic                 busy;
  logic                 overrun;

  modport master (
    output ena, sample_valid, sample_in, coef_we, coef_idx, coef_data,
    input  y_out, y_valid, busy, overrun
  );

  modport slave (
    input  ena, sample_valid, sample_in, coef_we, coef_idx, coef_data,
    output y_out, y_valid, busy, overrun
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one shared 8x8 signed multiplier walks the taps after each
// accepted sample, then publishes a shifted, saturated 8-bit result.
`timescale 1ns/1ps
module fir_mac_sequencer #(
  parameter int TAPS  = 4,
  parameter int SHIFT = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  fir_mac_sequencer_if.slave bus
);
  localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int AW = 16 + IW;
  localparam logic signed [AW-1:0] SAT_MAX = AW'(127);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-128);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                r_state;
  logic [IW-1:0]         r_k;
  logic signed [AW-1:0]  r_acc;
  logic signed [7:0]     r_y_out;
  logic                  r_y_valid;
  logic                  r_overrun;

  logic [TAPS-1:0][7:0]  w_x;
  logic [TAPS-1:0][7:0]  w_c;
  logic                  w_idle;
  logic                  w_accept;
  logic                  w_coef_wr;
  logic                  w_drop;
  logic                  w_last;
  logic signed [15:0]    w_prod;
  logic signed [AW-1:0]  w_acc_sum;
  logic signed [AW-1:0]  w_acc_shr;
  logic signed [7:0]     w_sat;

  assign w_idle    = (r_state == S_IDLE);
  assign w_accept  = bus.ena && w_idle && bus.sample_valid;
  assign w_coef_wr = bus.ena && w_idle && bus.coef_we;
  assign w_drop    = bus.ena && !w_idle && bus.sample_valid;
  assign w_last    = (r_k == IW'(TAPS - 1));

  assign w_prod    = $signed(w_x[r_k]) * $signed(w_c[r_k]);
  assign w_acc_sum = r_acc + AW'(w_prod);
  assign w_acc_shr = w_acc_sum >>> SHIFT;

  always_comb begin
    w_sat = w_acc_shr[7:0];
    if (w_acc_shr > SAT_MAX) begin
      w_sat = 8'sd127;
    end else if (w_acc_shr < SAT_MIN) begin
      w_sat = -8'sd128;
    end
  end

  // Each tap owns its delay-line stage and its coefficient register.
  for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
    logic signed [7:0] r_x_tap;
    logic signed [7:0] r_c_tap;
    logic signed [7:0] w_src;

    if (gi == 0) begin : g_head
      assign w_src = bus.sample_in;
    end else begin : g_body
      assign w_src = $signed(w_x[gi-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_x_tap <= '0;
        r_c_tap <= '0;
      end else begin
        if (w_accept) begin
          r_x_tap <= w_src;
        end
        if (w_coef_wr && (bus.coef_idx == IW'(gi))) begin
          r_c_tap <= bus.coef_data;
        end
      end
    end

    assign w_x[gi] = r_x_tap;
    assign w_c[gi] = r_c_tap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_acc     <= '0;
      r_y_out   <= '0;
      r_y_valid <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_y_valid <= (r_state == S_OUT) && bus.ena;
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
      if (bus.ena) begin
        case (r_state)
          S_IDLE: begin
            if (bus.sample_valid) begin
              r_acc   <= '0;
              r_k     <= '0;
              r_state <= S_MAC;
            end
          end
          S_MAC: begin
            r_acc <= w_acc_sum;
            r_k   <= r_k + 1'b1;
            // The result is taken from the sum that includes the final product.
            if (w_last) begin
              r_y_out <= w_sat;
              r_state <= S_OUT;
            end
          end
          S_OUT: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.y_out   = r_y_out;
  assign bus.y_valid = r_y_valid;
  assign bus.busy    = !w_idle;
  assign bus.overrun = r_overrun;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed plus randomized bench for fir_mac_sequencer, checked against a plain
// dot-product reference of the delay line and coefficient bank.
`timescale 1ns/1ps
module tb_fir_mac_sequencer;
  localparam int TAPS  = 4;
  localparam int SHIFT = 7;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  int   xm [TAPS];
  int   cm [TAPS];

  fir_mac_sequencer_if #(.TAPS(TAPS)) bus ();

  fir_mac_sequencer #(.TAPS(TAPS), .SHIFT(SHIFT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic void model_clear();
    for (int k = 0; k < TAPS; k++) begin
      xm[k] = 0;
      cm[k] = 0;
    end
  endfunction

  function automatic void model_push(input int s);
    for (int k = TAPS - 1; k > 0; k--) xm[k] = xm[k-1];
    xm[0] = s;
  endfunction

  function automatic int model_y();
    int acc;
    int v;
    acc = 0;
    for (int k = 0; k < TAPS; k++) acc += xm[k] * cm[k];
    v = acc >>> SHIFT;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  task automatic load_coef(input int idx, input int data);
    bus.coef_we   = 1'b1;
    bus.coef_idx  = 2'(idx);
    bus.coef_data = 8'(data);
    cm[idx] = data;
    @(negedge clk);
    bus.coef_we = 1'b0;
  endtask

  // Starts at a negedge with the DUT idle; ends at a negedge with the DUT idle again.
  task automatic transact(input int s, input bit idle_cw, input int cw_idx, input int cw_data,
                          input int drop_at, input int busy_cw_at,
                          input int frz_at, input int frz_len, input string tag);
    int cnt;
    int exp_y;
    bus.sample_valid = 1'b1;
    bus.sample_in    = 8'(s);
    if (idle_cw) begin
      bus.coef_we   = 1'b1;
      bus.coef_idx  = 2'(cw_idx);
      bus.coef_data = 8'(cw_data);
      cm[cw_idx] = cw_data;
    end
    model_push(s);
    exp_y = model_y();
    @(negedge clk);
    cnt = 1;
    bus.sample_valid = 1'b0;
    bus.coef_we      = 1'b0;
    check({tag, "_busy"}, 32'(bus.busy), 1);
    while (bus.y_valid !== 1'b1 && cnt < 40) begin
      bus.sample_valid = (cnt == drop_at);
      bus.sample_in    = 8'($urandom);
      bus.coef_we      = (cnt == busy_cw_at);
      bus.coef_idx     = '0;
      bus.coef_data    = 8'(0);
      bus.ena          = !(frz_len > 0 && cnt >= frz_at && cnt < frz_at + frz_len);
      @(negedge clk);
      cnt++;
      if (frz_len > 0 && cnt == frz_at + 1) check({tag, "_busy_frozen"}, 32'(bus.busy), 1);
    end
    bus.sample_valid = 1'b0;
    bus.coef_we      = 1'b0;
    bus.ena          = 1'b1;
    check({tag, "_latency"}, cnt, TAPS + 2 + frz_len);
    check({tag, "_y_out"}, $signed(bus.y_out), exp_y);
    $display("txn %s: sample=%0d y_out=%0d expected=%0d latency=%0d", tag, s, $signed(bus.y_out), exp_y, cnt);
    @(negedge clk);
    check({tag, "_pulse_end"}, 32'(bus.y_valid), 0);
    check({tag, "_idle"}, 32'(bus.busy), 0);
  endtask

  initial begin
    int seen;
    n_pass  = 0;
    n_total = 0;
    model_clear();
    rst_n            = 1'b0;
    bus.ena          = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    bus.coef_we      = 1'b0;
    bus.coef_idx     = '0;
    bus.coef_data    = '0;
    repeat (3) @(negedge clk);
    check("rst_y_out", $signed(bus.y_out), 0);
    check("rst_y_valid", 32'(bus.y_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_overrun", 32'(bus.overrun), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic filter
    load_coef(0, 64);
    load_coef(1, 64);
    transact(100, 0, 0, 0, 0, 0, 0, 0, "basic_100");
    transact(20, 0, 0, 0, 0, 0, 0, 0, "basic_20");

    // Overrun: a sample on the 2nd busy cycle is dropped
    check("overrun_before", 32'(bus.overrun), 0);
    transact(-37, 0, 0, 0, 2, 0, 0, 0, "overrun_drop");
    check("overrun_set", 32'(bus.overrun), 1);
    transact(55, 0, 0, 0, 0, 0, 0, 0, "after_drop");
    check("overrun_held", 32'(bus.overrun), 1);

    // Reset between edges in the middle of MAC
    bus.sample_valid = 1'b1;
    bus.sample_in    = 8'(77);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(bus.busy), 0);
    check("async_rst_y_out", $signed(bus.y_out), 0);
    check("async_rst_y_valid", 32'(bus.y_valid), 0);
    check("async_rst_overrun", 32'(bus.overrun), 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.y_valid === 1'b1) seen++;
    end
    check("no_valid_after_abort", seen, 0);
    transact(50, 0, 0, 0, 0, 0, 0, 0, "zero_coef_50");

    // Saturation
    for (int k = 0; k < TAPS; k++) load_coef(k, 127);
    for (int i = 0; i < 4; i++) transact(127, 0, 0, 0, 0, 0, 0, 0, "sat_pos");
    for (int i = 0; i < 4; i++) transact(-128, 0, 0, 0, 0, 0, 0, 0, "sat_neg");

    // Coefficient timing: busy write ignored, idle write used immediately
    transact(90, 0, 0, 0, 0, 2, 0, 0, "coef_busy_write");
    for (int k = 1; k < TAPS; k++) load_coef(k, 0);
    transact(64, 1, 0, 32, 0, 0, 0, 0, "coef_idle_write");

    // Freeze for 3 cycles inside MAC
    load_coef(1, -50);
    transact(-77, 0, 0, 0, 0, 0, 2, 3, "freeze");

    // Randomized traffic
    for (int i = 0; i < 16; i++) begin
      int s;
      int drop;
      int flen;
      if ($urandom_range(0, 1) == 1)
        load_coef(int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 255)) - 128);
      s    = int'($urandom_range(0, 255)) - 128;
      drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : 0;
      flen = int'($urandom_range(0, 2));
      transact(s, 0, 0, 0, drop, 0, int'($urandom_range(1, 3)), flen, "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
